// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the execute-stage multiply/divide unit.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider on a shared 64-bit accumulator.
// Multiply: acc = {partial_hi, multiplier}; shift-add, shifting right.
// Divide:   acc = {remainder, dividend/quotient}; restoring step, shifting left.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              mode_i,   // 0 multiply, 1 divide
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   op_i,     // multiplicand or divisor magnitude
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   mul_sum;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  // Both datapaths are evaluated; the mode selects which one feeds the accumulator.
  always_comb begin
    mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, op_i} : '0);
    // Trial remainder is {rem, next dividend bit}; it is always < 2*divisor,
    // so the low XLEN bits of the difference are exact when it does not borrow.
    div_ge  = acc_i[2*XLEN-1:XLEN-1] >= {1'b0, op_i};
    div_sub = acc_i[2*XLEN-2:XLEN-1] - op_i;
    if (mode_i) begin
      acc_o = {(div_ge ? div_sub : acc_i[2*XLEN-2:XLEN-1]), acc_i[XLEN-2:0], div_ge};
    end else begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage. Stalls the
// pipeline while iterating and presents a one-cycle result pulse.
module ex_muldiv
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN  = rv32_pkg::XLEN,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic            killE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] op_aE,
  input  logic [XLEN-1:0] op_bE,
  output logic [XLEN-1:0] resultE,
  output logic            doneE,
  output logic            stallE
);

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, is_div, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]   a_mag, b_mag, quot_s, rem_s;
  logic [2*XLEN-1:0] step_acc, prod_s;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_i (f3_q[2]),
    .acc_i  (acc_q),
    .op_i   (op_q),
    .acc_o  (step_acc)
  );

  assign accept  = (state_q == IDLE) && startE && !killE;
  assign stallE  = accept || (state_q == CALC) || (state_q == FIN);
  assign doneE   = (state_q == DONE);
  assign resultE = result_q;

  // Next-state, operand capture and result selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    op_d     = op_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;

    is_div   = funct3E[2];
    a_signed = (funct3E == FUNCT3_MULH) || (funct3E == FUNCT3_MULHSU) ||
               (funct3E == FUNCT3_DIV)  || (funct3E == FUNCT3_REM);
    b_signed = (funct3E == FUNCT3_MULH) || (funct3E == FUNCT3_DIV) ||
               (funct3E == FUNCT3_REM);
    neg_a    = a_signed && op_aE[XLEN-1];
    neg_b    = b_signed && op_bE[XLEN-1];
    a_mag    = neg_a ? ('0 - op_aE) : op_aE;
    b_mag    = neg_b ? ('0 - op_bE) : op_bE;

    prod_s   = neg_q ? ('0 - acc_q) : acc_q;
    quot_s   = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s    = neg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d  = funct3E;
          cnt_d = '0;
          if (is_div && (op_bE == '0)) begin
            result_d = funct3E[1] ? op_aE : '1;
            state_d  = DONE;
          end else if (is_div && !funct3E[0] && (op_aE == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (op_bE == '1)) begin
            result_d = funct3E[1] ? '0 : op_aE;
            state_d  = DONE;
          end else begin
            op_d    = is_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            // Remainder follows the dividend; everything else follows a^b.
            neg_d   = (is_div && funct3E[1]) ? neg_a : (neg_a ^ neg_b);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (killE) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIN;
        end
      end
      FIN: begin
        if (killE) begin
          state_d = IDLE;
        end else begin
          unique case (f3_q)
            FUNCT3_MUL:                result_d = prod_s[XLEN-1:0];
            FUNCT3_DIV, FUNCT3_DIVU:   result_d = quot_s;
            FUNCT3_REM, FUNCT3_REMU:   result_d = rem_s;
            default:                   result_d = prod_s[2*XLEN-1:XLEN];
          endcase
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startE = 1'b0;
  logic        killE = 1'b0;
  logic [2:0]  funct3E = '0;
  logic [31:0] op_aE = '0;
  logic [31:0] op_bE = '0;
  logic [31:0] resultE;
  logic        doneE;
  logic        stallE;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.XLEN(32), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .startE  (startE),
    .killE   (killE),
    .funct3E (funct3E),
    .op_aE   (op_aE),
    .op_bE   (op_bE),
    .resultE (resultE),
    .doneE   (doneE),
    .stallE  (stallE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle. Edges counted include the accept edge,
  // so a normal op completes after 34 edges and a special case after 1.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_edges);
    int edges;
    int stall_cnt;
    bit seen;
    funct3E = f3; op_aE = a; op_bE = b; startE = 1'b1; killE = 1'b0;
    #1;
    chk({tag, "_stall_accept"}, 32'(stallE), 32'd1);
    stall_cnt = 1; edges = 0; seen = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      if (edges == 0) begin
        // Operands must be ignored after the accept edge.
        op_aE = ~a; op_bE = b ^ 32'h5A5A_0F0F;
      end
      @(negedge clk);
      edges++;
      if (doneE) seen = 1'b1;
      else if (stallE) stall_cnt++;
    end
    chk({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_edges));
    chk({tag, "_result"}, resultE, exp_r);
    chk({tag, "_stall_done"}, 32'(stallE), 32'd0);
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(doneE), 32'd0);
    chk({tag, "_result_clr"}, resultE, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_result", resultE, 32'd0);
    chk("reset_done", 32'(doneE), 32'd0);
    chk("reset_stall", 32'(stallE), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Multiply
    run_op("mul_7_m3", FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh_min", FUNCT3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu_max", FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu_m1", FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

    // Divide, back-to-back with startE held
    run_op("div_m7_2", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_100_7", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 34);

    // Special cases
    run_op("div_by0", FUNCT3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", FUNCT3_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Kill at CALC iteration 10
    funct3E = FUNCT3_DIVU; op_aE = 32'd1000; op_bE = 32'd3; startE = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    startE = 1'b0; killE = 1'b1;
    #1;
    chk("kill_stall_calc", 32'(stallE), 32'd1);
    @(negedge clk);
    chk("kill_stall_after", 32'(stallE), 32'd0);
    chk("kill_done_after", 32'(doneE), 32'd0);
    killE = 1'b0;
    begin
      int dones = 0;
      repeat (36) begin
        @(negedge clk);
        if (doneE) dones++;
      end
      chk("kill_no_done", 32'(dones), 32'd0);
    end
    run_op("divu_9_3", FUNCT3_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Asynchronous reset in CALC iteration 20
    funct3E = FUNCT3_MUL; op_aE = 32'd123; op_bE = 32'd456; startE = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    startE = 1'b0;
    #1;
    chk("rst_calc_stall_before", 32'(stallE), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_calc_stall", 32'(stallE), 32'd0);
    chk("rst_calc_done", 32'(doneE), 32'd0);
    chk("rst_calc_result", resultE, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("mul_3_4", FUNCT3_MUL, 32'd3, 32'd4, 32'd12, 34);

    // Asynchronous reset while a result is presented
    funct3E = FUNCT3_DIV; op_aE = 32'd5; op_bE = 32'd0; startE = 1'b1;
    @(negedge clk);
    chk("rst_done_pre_done", 32'(doneE), 32'd1);
    chk("rst_done_pre_result", resultE, 32'hFFFF_FFFF);
    startE = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_done_result", resultE, 32'd0);
    chk("rst_done_done", 32'(doneE), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // startE with killE in IDLE must not accept
    funct3E = FUNCT3_MUL; op_aE = 32'd2; op_bE = 32'd2; startE = 1'b1; killE = 1'b1;
    #1;
    chk("idle_kill_stall", 32'(stallE), 32'd0);
    @(negedge clk);
    startE = 1'b0; killE = 1'b0;
    #1;
    chk("idle_kill_stall_next", 32'(stallE), 32'd0);
    begin
      int dones = 0;
      repeat (36) begin
        @(negedge clk);
        if (doneE) dones++;
      end
      chk("idle_kill_no_done", 32'(dones), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the ID/EX register outputs: forwarded operands, funct3, and an M-extension start qualifier.
- Holds the instruction in E by raising a stall request until the result is ready, then presents a one-cycle result to the execute-stage writeback mux, which feeds EX/MEM.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- startE  in  1  the instruction in E is an M-extension op (opcode 0110011, funct7 0000001), qualified valid.
- killE  in  1  flush of the E-stage instruction; same signal that drives the ID/EX flush.
- funct3E  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_aE  in  32  rs1 value after forwarding.
- op_bE  in  32  rs2 value after forwarding.
- resultE  out  32  result. Valid only while doneE=1, otherwise 0.
- doneE  out  1  one-cycle result-valid pulse.
- stallE  out  1  hold PC, IF/ID and ID/EX; bubble EX/MEM.

Behaviour:
- Reset: rst=1 asynchronously forces state IDLE, counter 0, all internal registers 0, resultE=0, doneE=0, stallE=0. Reset applies mid-operation; the operation is discarded.
- States: IDLE, CALC, FIN, DONE.
- IDLE, accept edge (startE=1, killE=0):
  - Latch funct3.
  - Latch operand magnitudes. Signed sources are abs(): a is signed for MULH, MULHSU, DIV and REM; b is signed for MULH, DIV and REM.
  - Latch the result sign.
  - Load counter 0 and go to CALC.
- Special divide cases bypass CALC and FIN, going straight to DONE at the accept edge:
  - b=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - DIV/REM with a=0x80000000 and b=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- CALC, one iteration per edge, 32 edges (counter 0..31). Go to FIN on the edge where counter=31.
  - Multiply: radix-2 shift-add into a 64-bit product.
  - Divide: restoring step, 33-bit trial subtract, quotient bit shifted in.
- FIN, one edge:
  - Apply sign: two's-complement negate of the 64-bit product or quotient. The remainder takes the sign of the dividend.
  - Select the output word: low 32 bits for MUL; high 32 bits for MULH, MULHSU and MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Register the word into resultE and go to DONE.
- DONE: doneE=1 for exactly this cycle and resultE holds the result. Next edge goes to IDLE unconditionally.
  - startE is still 1 in DONE because the same instruction is still in E. It must not re-trigger.
  - Leaving DONE clears resultE to 0.
- stallE is combinational: (state==IDLE && startE && !killE) || state==CALC || state==FIN.
  - stallE is low in DONE, so ID/EX advances on the DONE edge.
- Latency, counted from the accept edge:
  - Normal ops: doneE rises after the 33rd subsequent edge. stallE is high for 34 cycles and the instruction spends 35 cycles in E.
  - Special cases: doneE rises after the accept edge. stallE is high for 1 cycle.
- Kill:
  - killE=1 in CALC or FIN: the next edge goes to IDLE, doneE is not asserted, and the operation is lost.
  - killE=1 in DONE: still goes to IDLE, with no effect.
  - killE=1 with startE=1 in IDLE: not accepted, and stallE=0.
- Back-to-back ops: the op following in E is accepted in the IDLE cycle after DONE. There is no dead cycle beyond that.
- Operands are sampled only at the accept edge. Changes on op_aE and op_bE afterwards are ignored.

Decomposition:
- Shared package (rv32_pkg):
  - XLEN.
  - FUNCT3_MUL..FUNCT3_REMU constants.
  - OPC_OP = 7'b0110011 and FUNCT7_MULDIV = 7'b0000001.
  - muldiv_state_t enum {IDLE, CALC, FIN, DONE}.
- One sub-module: muldiv_step, combinational.
  - Inputs: mode, partial product/remainder, operand.
  - Outputs: next product, or next remainder/quotient bit.
  - Instantiated once inside ex_muldiv.

Test Plan:
1. MUL with a=7, b=0xFFFFFFFD -> resultE=0xFFFFFFEB. doneE is high exactly one cycle, 33 edges after accept. stallE is high for 34 cycles, then low in the DONE cycle.
2. Multiply-high cases:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Divide cases:
   - DIV -7/2 -> 0xFFFFFFFD.
   - REM -7/2 -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14.
   - REMU 100/7 -> 2.
   - Run these back-to-back with startE held; each result is returned once, with no duplicate doneE.
4. Special cases, each with doneE one edge after accept:
   - DIV 5/0 -> 0xFFFFFFFF.
   - REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM 0x80000000/0xFFFFFFFF -> 0.
5. Kill: killE=1 at CALC iteration 10 -> IDLE next edge, no doneE, stallE low. Then DIVU 9/3 started immediately -> 3.
6. Reset:
   - rst pulsed at iteration 20 -> resultE, doneE and stallE go to 0 without waiting for a clock edge.
   - After release, MUL 3x4 -> 12.
   - startE=1 with killE=1 in IDLE -> no accept, stallE=0.
